serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract controller for the SAP ALU path. It time-multiplexes one full-adder cell across WIDTH cycles, one bit per clock, LSB first, instead of a WIDTH-wide ripple adder. It captures operands on a START handshake, sequences the shift/carry registers, and presents the result with CARRY, OVERFLOW and ZERO flags plus a one-cycle DONE pulse. It sits between the accumulator/B-register and the bus driver.

---
 rtl/sap_alu_pkg.sv | 12 +
 rtl/fa.sv | 16 +
 rtl/serial_adder_ctrl.sv | 109 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_alu_pkg.sv
// Shared types and defaults for the SAP ALU path.
package sap_alu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } ser_state_t;

  localparam int SAP_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fa.sv
// Gate-level one-bit full adder, the shared datapath cell of the serial adder.
module fa (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic COUT
);

  logic p;

  assign p    = A ^ B;
  assign SUM  = p ^ CIN;
  assign COUT = (A & B) | (CIN & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full adder reused across WIDTH cycles, LSB first.
//
// state  | meaning
// IDLE   | waiting for START; result and flags hold the last completed operation
// SHIFT  | one operand bit per cycle through the fa cell, BUSY high
// FINISH | one-cycle DONE pulse with result and flags valid
module serial_adder_ctrl
  import sap_alu_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             ZERO
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-2:0] res_reg;
  logic [CNT_W-1:0] cnt;
  logic             carry_reg, msb_cin;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] res_nxt;

  fa u_fa (
    .A    (a_reg[0]),
    .B    (b_reg[0]),
    .CIN  (carry_reg),
    .SUM  (fa_sum),
    .COUT (fa_cout)
  );

  // res_reg keeps only the upper WIDTH-1 bits; the full word exists one bit early as res_nxt
  assign res_nxt  = {fa_sum, res_reg};
  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // BUSY/DONE come straight from flops so they never glitch on a state decode
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      cnt       <= '0;
      carry_reg <= 1'b0;
      msb_cin   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      SUM       <= '0;
      CARRY     <= 1'b0;
      OVERFLOW  <= 1'b0;
      ZERO      <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt == SHIFT);
      DONE  <= (state_nxt == FINISH);
      case (state)
        IDLE: begin
          if (START) begin
            a_reg     <= A;
            b_reg     <= SUB ? ~B : B;
            carry_reg <= SUB;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_cout;
          res_reg   <= res_nxt[WIDTH-1:1];
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_PEN) msb_cin <= fa_cout;
          if (last_bit) begin
            SUM      <= res_nxt;
            CARRY    <= fa_cout;
            OVERFLOW <= msb_cin ^ fa_cout;
            ZERO     <= (res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: arithmetic reference model checked every cycle plus directed literal cases.
module tb_serial_adder_ctrl;
  import sap_alu_pkg::*;

  localparam int W = SAP_WIDTH_DEFAULT;

  logic         CLK = 1'b0;
  logic         CLR = 1'b1;
  logic         START = 1'b0;
  logic         SUB = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY, DONE, CARRY, OVERFLOW, ZERO;
  logic [W-1:0] SUM;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .SUB(SUB), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .CARRY(CARRY), .OVERFLOW(OVERFLOW), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: unsigned result/carry, signed range test for overflow
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic v);
    longint ua, ub, sa, sb, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (s) begin
      r    = W'(ua - ub);
      c    = (ua >= ub);
      sres = sa - sb;
    end else begin
      r    = W'(ua + ub);
      c    = ((ua + ub) >> W) != 0;
      sres = sa + sb;
    end
    v = (sres > ((longint'(1) << (W - 1)) - 1)) || (sres < -(longint'(1) << (W - 1)));
  endfunction

  // Timeline model: m_rem counts cycles remaining until the operation is retired
  int           m_rem = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_c = 1'b0, m_v = 1'b0, m_z = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         op_s = 1'b0;

  always @(posedge CLK) begin
    if (CLR) begin
      m_rem = 0;
      m_sum = '0;
      m_c = 1'b0;
      m_v = 1'b0;
      m_z = 1'b0;
    end else if (m_rem == 0) begin
      if (START) begin
        op_a  = A;
        op_b  = B;
        op_s  = SUB;
        m_rem = W + 1;
      end
    end else begin
      m_rem--;
      if (m_rem == 1) begin
        ref_op(op_a, op_b, op_s, m_sum, m_c, m_v);
        m_z = (m_sum == '0);
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk_b("busy", BUSY, m_rem >= 2);
      chk_b("done", DONE, m_rem == 1);
      chk_w("sum", SUM, m_sum);
      chk_b("carry", CARRY, m_c);
      chk_b("overflow", OVERFLOW, m_v);
      chk_b("zero", ZERO, m_z);
    end
  end

  // Issue one operation from IDLE; returns the DONE latency in cycles after the START edge
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
    @(negedge CLK);
    A = a; B = b; SUB = s; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    SUB = 1'($urandom);
    lat = 1;
    while (!DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] es, input logic ec, input logic ev, input logic ez);
    int lat;
    do_op(a, b, s, lat);
    chk_i({nm, "_latency"}, lat, W + 1);
    chk_w({nm, "_sum"}, SUM, es);
    chk_b({nm, "_carry"}, CARRY, ec);
    chk_b({nm, "_ovf"}, OVERFLOW, ev);
    chk_b({nm, "_zero"}, ZERO, ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone, prev, first, busy_cnt;

    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    chk_b("rst_busy", BUSY, 1'b0);
    chk_b("rst_done", DONE, 1'b0);
    chk_w("rst_sum", SUM, 8'h00);
    chk_b("rst_carry", CARRY, 1'b0);
    CLR = 1'b0;

    // Case 1 with a BUSY-cycle count
    @(negedge CLK);
    A = 8'h3C; B = 8'h05; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    busy_cnt = 0;
    lat = 1;
    while (!DONE && lat < 20) begin
      if (BUSY) busy_cnt++;
      @(negedge CLK);
      lat++;
    end
    chk_i("add1_busy_cycles", busy_cnt, 8);
    chk_i("add1_latency", lat, 9);
    chk_w("add1_sum", SUM, 8'h41);
    chk_b("add1_carry", CARRY, 1'b0);
    chk_b("add1_ovf", OVERFLOW, 1'b0);
    chk_b("add1_zero", ZERO, 1'b0);

    run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sub_borrow", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",    8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("sub_zero",   8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

    // START during SHIFT is ignored
    @(negedge CLK);
    A = 8'h12; B = 8'h34; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    A = 8'hFF; B = 8'hFF; SUB = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; SUB = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (DONE) begin
        ndone++;
        chk_w("ignore_sum", SUM, 8'h46);
      end
      @(negedge CLK);
    end
    chk_i("ignore_done_count", ndone, 1);

    // CLR in the 4th BUSY cycle aborts without DONE
    @(negedge CLK);
    A = 8'h22; B = 8'h11; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk_b("abort_busy_before", BUSY, 1'b1);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk_b("abort_busy", BUSY, 1'b0);
    chk_b("abort_done", DONE, 1'b0);
    chk_w("abort_sum", SUM, 8'h00);
    chk_b("abort_flags", CARRY | OVERFLOW | ZERO, 1'b0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (DONE) ndone++;
      @(negedge CLK);
    end
    chk_i("abort_no_done", ndone, 0);
    run_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

    // START held high: one result every W+2 cycles
    @(negedge CLK);
    A = 8'h01; B = 8'h01; SUB = 1'b0; START = 1'b1;
    ndone = 0;
    prev = 0;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (DONE) begin
        ndone++;
        chk_w("b2b_sum", SUM, 8'h02);
        if (first == 0) begin
          chk_i("b2b_first", i, 9);
          first = i;
        end else begin
          chk_i("b2b_period", i - prev, 10);
        end
        prev = i;
      end
    end
    START = 1'b0;
    chk_i("b2b_count", ndone, 4);
    repeat (12) @(negedge CLK);

    // Random sweep; the model process checks every cycle
    ndone = 0;
    for (int n = 0; n < 500; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      do_op(W'($urandom), W'($urandom), 1'($urandom), lat);
      if (DONE) ndone++;
    end
    chk_i("sweep_done_count", ndone, 500);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
